// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared lane geometry, lane array type and writer FSM states
package simd_pkg;

   localparam int LANES  = 16;
   localparam int DATA_W = 32;
   localparam int IDX_W  = $clog2(LANES);

   typedef logic [LANES-1:0][DATA_W-1:0] lane_arr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_DONE
   } state_t;

endpackage

// File: rtl/lane_pick.sv
// rtl/lane_pick.sv - lowest-set-bit finder over a lane mask
module lane_pick
   import simd_pkg::*;
(
   input  logic [LANES-1:0] mask,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top so the lowest set bit is the last one to win.
   always_comb begin
      idx = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mask[i]) idx = IDX_W'(i);
      end
   end

   assign any = |mask;

endmodule

// File: rtl/vres_mem_writer.sv
// rtl/vres_mem_writer.sv - stores a captured lane array lane by lane through one write port
module vres_mem_writer
   import simd_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  lane_arr_t         a_res,
   input  logic [LANES-1:0]  lane_mask,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done
);

   state_t            state, state_nxt;
   lane_arr_t         data_q;
   logic [ADDR_W-1:0] base_q;
   logic [LANES-1:0]  pending;
   logic [LANES-1:0]  pick_in;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;

   // The current lane is always the lowest pending bit, so clearing the
   // lowest set bit yields the remaining lanes after an accepted write.
   assign pick_in = (state == S_IDLE) ? lane_mask : (pending & (pending - LANES'(1)));

   lane_pick u_pick (
      .mask (pick_in),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
      return base + ADDR_W'({idx, 2'b00});
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = pick_any ? S_WRITE : S_DONE;
         S_WRITE: if (mem_ready && !pick_any) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         base_q    <= '0;
         pending   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (state == S_IDLE && start) begin
         data_q    <= a_res;
         base_q    <= base_addr;
         pending   <= lane_mask;
         mem_addr  <= lane_addr(base_addr, pick_idx);
         mem_wdata <= a_res[pick_idx];
      end else if (state == S_WRITE && mem_ready) begin
         pending <= pick_in;
         if (pick_any) begin
            mem_addr  <= lane_addr(base_q, pick_idx);
            mem_wdata <= data_q[pick_idx];
         end
      end
   end

   assign mem_we = (state == S_WRITE);
   assign busy   = (state != S_IDLE);
   assign done   = (state == S_DONE);

endmodule

// File: tb/tb_vres_mem_writer.sv
// tb/tb_vres_mem_writer.sv - randomized self-checking bench for vres_mem_writer
module tb_vres_mem_writer;
   import simd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   lane_arr_t   a_res;
   logic [15:0] lane_mask;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;
   int stall_cfg[16];

   always #5 clk = ~clk;

   vres_mem_writer #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .a_res     (a_res),
      .lane_mask (lane_mask),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done)
   );

   task automatic scramble_inputs;
      for (int i = 0; i < 16; i++) a_res[i] = $urandom;
      base_addr = $urandom;
      lane_mask = 16'($urandom);
   endtask

   task automatic clear_stalls;
      for (int i = 0; i < 16; i++) stall_cfg[i] = 0;
   endtask

   function automatic lane_arr_t pattern_a0;
      lane_arr_t d;
      for (int i = 0; i < 16; i++) d[i] = 32'hA000_0000 + 32'(i);
      return d;
   endfunction

   // Model: one store per set lane in ascending order, each held for its
   // stall count plus the accepting cycle, followed by a single done cycle.
   task automatic run_vec(input string name, input logic [15:0] mask, input logic [31:0] base,
                          input lane_arr_t data, input bit noisy);
      logic        e_we[$];
      logic [31:0] e_addr[$];
      logic [31:0] e_data[$];
      logic        e_rdy[$];
      logic        e_done[$];
      for (int l = 0; l < 16; l++) begin
         if (mask[l]) begin
            for (int s = 0; s <= stall_cfg[l]; s++) begin
               e_we.push_back(1'b1);
               e_addr.push_back(base + 32'(l * 4));
               e_data.push_back(data[l]);
               e_rdy.push_back(s == stall_cfg[l]);
               e_done.push_back(1'b0);
            end
         end
      end
      e_we.push_back(1'b0);
      e_addr.push_back(32'h0);
      e_data.push_back(32'h0);
      e_rdy.push_back(1'($urandom));
      e_done.push_back(1'b1);

      @(negedge clk);
      start     = 1'b1;
      lane_mask = mask;
      base_addr = base;
      a_res     = data;
      mem_ready = 1'($urandom);
      @(posedge clk);
      for (int c = 0; c < e_we.size(); c++) begin
         @(negedge clk);
         start = noisy ? 1'($urandom) : 1'b0;
         if (noisy) scramble_inputs();
         mem_ready = e_rdy[c];
         tests++;
         if (mem_we !== e_we[c]) begin
            fails++;
            $display("FAIL %s mem_we cycle %0d: got %b want %b", name, c + 1, mem_we, e_we[c]);
         end
         if (e_we[c]) begin
            tests++;
            if (mem_addr !== e_addr[c]) begin
               fails++;
               $display("FAIL %s mem_addr cycle %0d: got %h want %h", name, c + 1, mem_addr, e_addr[c]);
            end
            tests++;
            if (mem_wdata !== e_data[c]) begin
               fails++;
               $display("FAIL %s mem_wdata cycle %0d: got %h want %h", name, c + 1, mem_wdata, e_data[c]);
            end
         end
         tests++;
         if (done !== e_done[c]) begin
            fails++;
            $display("FAIL %s done cycle %0d: got %b want %b", name, c + 1, done, e_done[c]);
         end
         tests++;
         if (busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy cycle %0d: got %b want 1", name, c + 1, busy);
         end
         @(posedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
         fails++;
         $display("FAIL %s idle after done: busy=%b done=%b we=%b want 0 0 0", name, busy, done, mem_we);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset outputs: we=%b addr=%h data=%h busy=%b done=%b want all 0",
                  mem_we, mem_addr, mem_wdata, busy, done);
      end
      rst = 1'b0;
   endtask

   task automatic test_full_mask;
      clear_stalls();
      run_vec("full_mask", 16'hFFFF, 32'h1000, pattern_a0(), 1'b0);
   endtask

   task automatic test_sparse_mask;
      clear_stalls();
      run_vec("mask_8001", 16'h8001, 32'h1000, pattern_a0(), 1'b0);
   endtask

   task automatic test_stall;
      clear_stalls();
      stall_cfg[5] = 3;
      run_vec("stall_lane5", 16'hFFFF, 32'h1000, pattern_a0(), 1'b1);
   endtask

   task automatic test_zero_mask;
      clear_stalls();
      run_vec("mask_zero", 16'h0000, 32'h1000, pattern_a0(), 1'b0);
   endtask

   task automatic test_wrap;
      clear_stalls();
      run_vec("addr_wrap", 16'hFFFF, 32'hFFFF_FFF8, pattern_a0(), 1'b0);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start     = 1'b1;
      lane_mask = 16'hFFFF;
      base_addr = 32'h1000;
      a_res     = pattern_a0();
      mem_ready = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start     = 1'b0;
         mem_ready = (c < 8);
         rst       = (c == 8);
         tests++;
         if (mem_we !== 1'b1 || mem_addr !== 32'h1000 + 32'((c - 1) * 4) ||
             mem_wdata !== 32'hA000_0000 + 32'(c - 1)) begin
            fails++;
            $display("FAIL reset_mid write cycle %0d: we=%b addr=%h data=%h want 1 %h %h",
                     c, mem_we, mem_addr, mem_wdata, 32'h1000 + 32'((c - 1) * 4), 32'hA000_0000 + 32'(c - 1));
         end
         @(posedge clk);
      end
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid outputs: we=%b addr=%h data=%h busy=%b done=%b want all 0",
                  mem_we, mem_addr, mem_wdata, busy, done);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid late done: done=%b busy=%b want 0 0", done, busy);
      end
      clear_stalls();
      run_vec("after_reset", 16'hFFFF, 32'h1000, pattern_a0(), 1'b0);
   endtask

   task automatic test_random;
      lane_arr_t   d;
      logic [15:0] m;
      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < 16; i++) begin
            d[i]         = $urandom;
            stall_cfg[i] = $urandom_range(0, 3);
         end
         case (it % 5)
            0:       m = 16'hFFFF;
            1:       m = 16'h0000;
            default: m = 16'($urandom);
         endcase
         run_vec("random", m, $urandom, d, 1'b1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      mem_ready = 1'b0;
      base_addr = 32'h0;
      lane_mask = 16'h0;
      a_res     = '0;
      clear_stalls();
      test_reset();
      test_full_mask();
      test_sparse_mask();
      test_stall();
      test_zero_mask();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vres_mem_writer.md
# vres_mem_writer

Vector-result writeback sequencer for the SIMD FIR datapath. Consumes the 16×32-bit lane array produced by the vector-result unpacking stage and stores it lane by lane through the single 32-bit data-memory write port. Uses a valid/ready handshake toward memory and supports a per-lane write mask. Reports busy/done to the control unit so the pipeline can stall on vector stores.

## Interface
- LANES, 16, number of vector lanes
- DATA_W, 32, lane width in bits
- ADDR_W, 32, byte address width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to store a vector; sampled only in IDLE
- base_addr  in  ADDR_W  byte address of lane 0; sampled with start
- a_res  in  [LANES][DATA_W]  lane array, lane i = a_res[i]; sampled with start
- lane_mask  in  LANES  bit i=1 enables the store of lane i; sampled with start
- mem_we  out  1  write request valid
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepts the current write this cycle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE: on start=1, latch a_res, base_addr and lane_mask into internal registers; if latched mask is nonzero, go to WRITE with the lane pointer at the lowest set mask bit; if mask is all zero, go directly to DONE.
- WRITE: mem_we=1, mem_addr = base + 4·lane, mem_wdata = latched lane value. mem_addr, mem_wdata and mem_we hold stable while mem_ready=0. On mem_we && mem_ready: clear that lane's pending bit; advance to the next higher set bit (masked lanes are skipped with zero cycles); if none remains, go to DONE.
- DONE: done=1 for exactly one cycle, mem_we=0, then return to IDLE.
- start outside IDLE is ignored; captured data is not affected by later changes of the inputs.
- Address arithmetic is modulo 2^ADDR_W (wraps silently); lane offset = lane index << 2.
- Lane order is always ascending index.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, state=IDLE, pending mask=0.
- All outputs are registered or decoded from registered state; no combinational path from start or a_res to any output. mem_ready may combinationally affect only next-state logic.
- start at cycle 0 → first mem_we at cycle 1. With the full mask and mem_ready held high, writes occur in cycles 1–16, done in cycle 17, IDLE in cycle 18 (can accept a new start at cycle 18).
- Each mem_ready=0 cycle during WRITE adds exactly one cycle of latency.
- Mask with k set bits, ready always high: done at cycle k+1; k=0 → done at cycle 1.
- busy=1 in WRITE and DONE; busy=0 in IDLE.
- rst asserted in any state, including mid-WRITE with a write pending: the next edge forces the reset values. The interrupted write is not completed, and done is not pulsed.
- start asserted in the same cycle as done is ignored.

## Structure
- Shared package simd_pkg: LANES, DATA_W, the lane_arr_t typedef (logic [LANES-1:0][DATA_W-1:0]), and the FSM state enum.
- One sub-module, lane_pick: combinational lowest-set-bit finder over the LANES-bit pending mask; outputs the index and an any-set flag. It is used both for the initial lane selection and for advancing.
- The top level holds the FSM, the capture registers, the pending-mask register and the output registers.

## Test plan
- Full mask, mem_ready=1, base 0x1000, a_res[i]=0xA0000000+i → 16 writes at addresses 0x1000…0x103C in cycles 1–16 with matching data; done in cycle 17.
- Mask 0x8001, ready=1 → exactly two writes: (0x1000, lane0) at cycle 1 and (0x103C, lane15) at cycle 2; done at cycle 3.
- Full mask, ready low for 3 cycles on lane 5 → address 0x1014 and its data hold stable for 4 cycles; done at cycle 20; a_res changed after start has no effect on the stored data.
- Mask 0x0000 → no mem_we; done at cycle 1; busy high in that cycle only.
- base 0xFFFFFFF8 with full mask → lane 2 written at address 0x00000000 (address wrap).
- rst asserted during lane 7 → all outputs are 0 the next cycle, no done pulse; a new start afterwards behaves as in the first scenario.
